write_resp_channel_arb: RTL and testbench
=========================================

// Module: write_resp_channel_arb
// PURPOSE
//  Upstream stage of the write response channel decoder. Collects B responses from two slave-side ports (M00, M01).
//  Round-robin arbitrates between them and registers the winner into a one-entry output stage.
//  Drives Sel_Resp_ID / Sel_Write_Resp / Sel_Valid to the decoder and takes Sel_Ready back from the addressed master.
// PARAMETERS
//  Num_Of_Masters   4                        number of upstream masters
//  Master_ID_Width  $clog2(Num_Of_Masters)   width of bid and Sel_Resp_ID
//  Err_Cnt_Width    16                       error counter width (WRESP_ERR_CNT_EN only)
// PORTS
//  ACLK            in   1                 clock, all state on rising edge
//  ARESETN         in   1                 reset, asynchronous, active-low
//  M00_AXI_bid     in   Master_ID_Width   originating master ID of slave-0 response
//  M00_AXI_bresp   in   2                 slave-0 write response
//  M00_AXI_bvalid  in   1                 slave-0 response valid
//  M00_AXI_bready  out  1                 slave-0 response accepted
//  M01_AXI_bid     in   Master_ID_Width   as M00, slave 1
//  M01_AXI_bresp   in   2                 as M00, slave 1
//  M01_AXI_bvalid  in   1                 as M00, slave 1
//  M01_AXI_bready  out  1                 as M00, slave 1
//  Sel_Resp_ID     out  Master_ID_Width   destination master of held response
//  Sel_Write_Resp  out  2                 held response code
//  Sel_Valid       out  1                 held response valid
//  Sel_Ready       in   1                 bready of addressed master, muxed externally
//  Err_Count       out  Err_Cnt_Width     SLVERR/DECERR count (WRESP_ERR_CNT_EN only)
// BEHAVIOUR
//  Reset: Sel_Valid=0, Sel_Resp_ID=0, Sel_Write_Resp=2'b00, Err_Count=0, state EMPTY, rr pointer favours M00.
//    Mxx_AXI_bready are combinational and read 0 while ARESETN=0.
//  Output-stage FSM:
//    EMPTY -> FULL on load.
//    FULL -> FULL on load while Sel_Ready=1.
//    FULL -> EMPTY on Sel_Ready=1 with no load.
//    FULL holds while Sel_Ready=0.
//  Sel_Valid = (state==FULL).
//  load_en = (state==EMPTY) || Sel_Ready. Full throughput: one response per cycle.
//  Arbitration: combinational over M00/M01 bvalid.
//    Both valid: grant the slave not granted last. One valid: grant it.
//    The pointer updates only on an accepted transfer.
//  Mxx_AXI_bready = grant[xx] && load_en. bready may depend on bvalid; at most one bready is high per cycle.
//  On load: Sel_Resp_ID <= granted bid, Sel_Write_Resp <= granted bresp.
//    Latency: 1 cycle from accepted bvalid to Sel_Valid.
//  Sel_Resp_ID and Sel_Write_Resp stay stable while Sel_Valid=1 and Sel_Ready=0 (AXI B rule).
//  A loser keeps bvalid high; it is never dropped.
//  Reset mid-transfer discards the held response. The slave handshake already completed; no replay.
//  bresp values pass unmodified, EXOKAY included.
// CONFIGURATION
//  Macro WRESP_ERR_CNT_EN.
//  Defined: Err_Count increments on each load with bresp[1]=1 (SLVERR/DECERR).
//    The counter saturates at all-ones; it has no wrap.
//  Undefined: the Err_Count port and its counter are absent. All other behaviour is identical.
// STRUCTURE
//  Package axi_ic_pkg holds:
//    resp_t enum {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11}
//    wresp_state_t enum {EMPTY, FULL}
//  Sub-module wresp_rr_arb: 2-requester round-robin grant.
//    Inputs: req[1:0], accept. Output: one-hot grant[1:0]. Holds the pointer flop.
//  The output register and FSM stay in the top module.
// TESTING
//  1 Single response: M00 bvalid, bid=2, bresp=OKAY, Sel_Ready=1.
//    -> M00_AXI_bready=1 same cycle; next cycle Sel_Valid=1, Sel_Resp_ID=2, Sel_Write_Resp=00; Sel_Valid=0 one cycle later.
//  2 Contention after reset: M00 (bid=1) and M01 (bid=3) valid together, Sel_Ready=1.
//    -> ID 1 out first, ID 3 on the next cycle. With both held valid, grants alternate M00/M01 every cycle.
//  3 Backpressure: Sel_Ready=0 for 5 cycles with both slaves valid.
//    -> Sel_Valid, Sel_Resp_ID and Sel_Write_Resp are stable; both breadys are 0 after the first load.
//    -> The next response is loaded the cycle Sel_Ready returns to 1.
//  4 Throughput: 8 back-to-back M01 responses, Sel_Ready=1.
//    -> 8 consecutive Sel_Valid cycles in order, no bubbles.
//  5 Reset mid-operation: drop ARESETN while Sel_Valid=1.
//    -> Sel_Valid=0 without waiting for ACLK. After release, both valid -> M00 granted first.
//  6 WRESP_ERR_CNT_EN: 3 SLVERR, 1 DECERR, 2 OKAY, 1 EXOKAY -> Err_Count=4.
//    Preload near max via force -> count holds at all-ones.

Source files
------------

// File: rtl/axi_ic_pkg.sv
// axi_ic_pkg: shared AXI interconnect types (B response codes, write-response output-stage states)
package axi_ic_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} wresp_state_t;
endpackage

// File: rtl/wresp_rr_arb.sv
// wresp_rr_arb: 2-requester round-robin grant; ports ACLK, ARESETN (async, active-low), req[1:0], accept, one-hot grant[1:0]
module wresp_rr_arb (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);
  logic last_q, last_d;
  always_comb begin
    grant[0] = req[0] && (!req[1] || last_q);
    grant[1] = req[1] && (!req[0] || !last_q);
    last_d   = accept ? grant[1] : last_q;
  end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) last_q <= 1'b1;
    else          last_q <= last_d;
endmodule

// File: rtl/write_resp_channel_arb.sv
// write_resp_channel_arb: RR-arbitrates M00/M01 B responses into a one-entry Sel_* output stage; ports ACLK, ARESETN, Mxx_AXI_b*, Sel_Resp_ID/Sel_Write_Resp/Sel_Valid/Sel_Ready, Err_Count only with WRESP_ERR_CNT_EN
module write_resp_channel_arb
  import axi_ic_pkg::*;
#(
  parameter int Num_Of_Masters  = 4,
  parameter int Master_ID_Width = $clog2(Num_Of_Masters)
`ifdef WRESP_ERR_CNT_EN
  , parameter int Err_Cnt_Width = 16
`endif
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [Master_ID_Width-1:0] M00_AXI_bid,
  input  logic [1:0]                 M00_AXI_bresp,
  input  logic                       M00_AXI_bvalid,
  output logic                       M00_AXI_bready,
  input  logic [Master_ID_Width-1:0] M01_AXI_bid,
  input  logic [1:0]                 M01_AXI_bresp,
  input  logic                       M01_AXI_bvalid,
  output logic                       M01_AXI_bready,
  output logic [Master_ID_Width-1:0] Sel_Resp_ID,
  output logic [1:0]                 Sel_Write_Resp,
  output logic                       Sel_Valid,
  input  logic                       Sel_Ready
`ifdef WRESP_ERR_CNT_EN
  , output logic [Err_Cnt_Width-1:0] Err_Count
`endif
);
  wresp_state_t               state_q, state_d;
  logic [Master_ID_Width-1:0] id_q, id_d;
  resp_t                      resp_q, resp_d;
  logic [1:0]                 grant;
  logic                       load_en, load;
  wresp_rr_arb u_arb (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .req     ({M01_AXI_bvalid, M00_AXI_bvalid}),
    .accept  (load),
    .grant   (grant)
  );
  always_comb begin
    load_en        = (state_q == EMPTY) || Sel_Ready;
    M00_AXI_bready = grant[0] && load_en && ARESETN;
    M01_AXI_bready = grant[1] && load_en && ARESETN;
    load           = M00_AXI_bready || M01_AXI_bready;
    state_d        = load ? FULL : (Sel_Ready ? EMPTY : state_q);
    id_d           = load ? (grant[1] ? M01_AXI_bid : M00_AXI_bid) : id_q;
    resp_d         = load ? resp_t'(grant[1] ? M01_AXI_bresp : M00_AXI_bresp) : resp_q;
  end
  assign Sel_Valid      = (state_q == FULL);
  assign Sel_Resp_ID    = id_q;
  assign Sel_Write_Resp = resp_q;
`ifdef WRESP_ERR_CNT_EN
  logic [Err_Cnt_Width-1:0] err_q, err_d;
  always_comb err_d = (load && resp_d[1] && !(&err_q)) ? err_q + 1'b1 : err_q;
  assign Err_Count = err_q;
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) err_q <= '0;
    else          err_q <= err_d;
`endif
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state_q <= EMPTY;
      id_q    <= '0;
      resp_q  <= OKAY;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      resp_q  <= resp_d;
    end
endmodule

// File: tb/tb_write_resp_channel_arb.sv
// tb_write_resp_channel_arb: directed self-checking bench for write_resp_channel_arb
module tb_write_resp_channel_arb;
  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic [1:0] m0_bid = '0, m0_bresp = '0, m1_bid = '0, m1_bresp = '0;
  logic       m0_bvalid = 1'b0, m1_bvalid = 1'b0, m0_bready, m1_bready;
  logic [1:0] sel_id, sel_resp;
  logic       sel_valid, sel_ready = 1'b0;
  int         checks = 0, errors = 0;
`ifdef WRESP_ERR_CNT_EN
  logic [15:0] err_count;
`endif
  always #5 ACLK = ~ACLK;
  write_resp_channel_arb dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .M00_AXI_bid    (m0_bid),
    .M00_AXI_bresp  (m0_bresp),
    .M00_AXI_bvalid (m0_bvalid),
    .M00_AXI_bready (m0_bready),
    .M01_AXI_bid    (m1_bid),
    .M01_AXI_bresp  (m1_bresp),
    .M01_AXI_bvalid (m1_bvalid),
    .M01_AXI_bready (m1_bready),
    .Sel_Resp_ID    (sel_id),
    .Sel_Write_Resp (sel_resp),
    .Sel_Valid      (sel_valid),
    .Sel_Ready      (sel_ready)
`ifdef WRESP_ERR_CNT_EN
    , .Err_Count    (err_count)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [1:0] id, input logic [1:0] rsp);
    chk({tag, "_valid"}, sel_valid, v);
    chk({tag, "_id"}, sel_id, id);
    chk({tag, "_resp"}, sel_resp, rsp);
  endtask
  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, "_bready0"}, m0_bready, r0);
    chk({tag, "_bready1"}, m1_bready, r1);
  endtask
  task automatic do_reset();
    #2 ARESETN = 1'b0;
    #2 ARESETN = 1'b1;
    #1;
  endtask
  initial begin
    // reset state, bready gated low while in reset
    #2;
    m0_bvalid = 1'b1;
    #1;
    chk_out("rst", 1'b0, 2'd0, 2'b00);
    chk_rdy("rst", 1'b0, 1'b0);
    m0_bvalid = 1'b0;
    #4 ARESETN = 1'b1;
    tick();
    // 1: single response
    sel_ready = 1'b1;
    m0_bvalid = 1'b1; m0_bid = 2'd2; m0_bresp = 2'b00;
    #1;
    chk_rdy("t1_req", 1'b1, 1'b0);
    tick();
    m0_bvalid = 1'b0;
    chk_out("t1_load", 1'b1, 2'd2, 2'b00);
    tick();
    chk("t1_drain_valid", sel_valid, 1'b0);
    // 2: contention right after reset, M00 first then alternation
    do_reset();
    m0_bvalid = 1'b1; m0_bid = 2'd1; m0_bresp = 2'b00;
    m1_bvalid = 1'b1; m1_bid = 2'd3; m1_bresp = 2'b01;
    #1;
    chk_rdy("t2_first", 1'b1, 1'b0);
    tick();
    chk_out("t2_o1", 1'b1, 2'd1, 2'b00);
    chk_rdy("t2_second", 1'b0, 1'b1);
    tick();
    chk_out("t2_o2", 1'b1, 2'd3, 2'b01);
    chk_rdy("t2_third", 1'b1, 1'b0);
    tick();
    chk_out("t2_o3", 1'b1, 2'd1, 2'b00);
    tick();
    chk_out("t2_o4", 1'b1, 2'd3, 2'b01);
    // 3: backpressure holds output and blocks both slaves
    sel_ready = 1'b0;
    #1;
    chk_rdy("t3_block", 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("t3_hold", 1'b1, 2'd3, 2'b01);
      chk_rdy("t3_hold", 1'b0, 1'b0);
    end
    sel_ready = 1'b1;
    #1;
    chk_rdy("t3_resume", 1'b1, 1'b0);
    tick();
    chk_out("t3_next", 1'b1, 2'd1, 2'b00);
    m0_bvalid = 1'b0; m1_bvalid = 1'b0;
    tick();
    chk("t3_empty", sel_valid, 1'b0);
    // 4: eight back-to-back M01 responses without bubbles
    for (int i = 0; i < 8; i++) begin
      m1_bvalid = 1'b1; m1_bid = 2'(i); m1_bresp = 2'(i + 1);
      #1;
      chk_rdy("t4_req", 1'b0, 1'b1);
      tick();
      chk_out("t4_out", 1'b1, 2'(i), 2'(i + 1));
    end
    m1_bvalid = 1'b0;
    tick();
    chk("t4_empty", sel_valid, 1'b0);
    // 5: async reset mid-transfer; last grant was M00, reset must re-favour M00
    m0_bvalid = 1'b1; m0_bid = 2'd2; m0_bresp = 2'b10;
    tick();
    m0_bvalid = 1'b0;
    chk_out("t5_held", 1'b1, 2'd2, 2'b10);
    ARESETN = 1'b0;
    #1;
    chk_out("t5_async", 1'b0, 2'd0, 2'b00);
    m0_bvalid = 1'b1; m0_bid = 2'd0; m0_bresp = 2'b00;
    m1_bvalid = 1'b1; m1_bid = 2'd1; m1_bresp = 2'b00;
    #1;
    chk_rdy("t5_inrst", 1'b0, 1'b0);
    ARESETN = 1'b1;
    #1;
    chk_rdy("t5_post", 1'b1, 1'b0);
    tick();
    chk_out("t5_first", 1'b1, 2'd0, 2'b00);
    m0_bvalid = 1'b0; m1_bvalid = 1'b0;
    tick();
`ifdef WRESP_ERR_CNT_EN
    // 6: error counter and saturation
    do_reset();
    begin
      logic [1:0] codes [7] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01};
      for (int i = 0; i < 7; i++) begin
        m0_bvalid = 1'b1; m0_bresp = codes[i];
        tick();
      end
    end
    m0_bvalid = 1'b0;
    tick();
    chk("t6_count", err_count, 16'd4);
    force dut.err_q = 16'hFFFE;
    #1;
    release dut.err_q;
    for (int i = 0; i < 3; i++) begin
      m0_bvalid = 1'b1; m0_bresp = 2'b10;
      tick();
    end
    m0_bvalid = 1'b0;
    tick();
    chk("t6_sat", err_count, 16'hFFFF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
